// File: rtl/pio_pkg.sv
// Shared definitions for the input PIO: register map and edge-capture modes.
package pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_LATENCY = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_EDGECAP = 2'd3
  } pio_addr_e;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  function automatic logic addr_is(input logic [1:0] address, input pio_addr_e target);
    return address == 2'(target);
  endfunction

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser chain, previous-value register and per-bit edge detector.
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_RISING
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] sync_q,
  output logic [DATA_W-1:0] edge_det
);

  logic [DATA_W-1:0] stage_reg [SYNC_STAGES];
  logic [DATA_W-1:0] prev_reg;

  // Everything clears to 0 so the first post-reset compare sees no edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_reg[i] <= '0;
      end
      prev_reg <= '0;
    end else begin
      stage_reg[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
      prev_reg <= sync_q;
    end
  end

  assign sync_q = stage_reg[SYNC_STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_bit
      if (EDGE_MODE == EDGE_RISING) begin : g_rise
        assign edge_det[gi] = sync_q[gi] & ~prev_reg[gi];
      end else if (EDGE_MODE == EDGE_FALLING) begin : g_fall
        assign edge_det[gi] = ~sync_q[gi] & prev_reg[gi];
      end else begin : g_any
        assign edge_det[gi] = sync_q[gi] ^ prev_reg[gi];
      end
    end
  endgenerate

endmodule

// File: rtl/pio_in_capture.sv
// Avalon-MM input PIO with edge capture, maskable level irq and optional
// irq-latency counter (enabled by defining PIO_IN_CAPTURE_LATENCY_EN).
module pio_in_capture
  import pio_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_RISING
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  input  logic [DATA_W-1:0] in_port,
  output logic              irq
);

  logic              wr;
  logic [DATA_W-1:0] sync_q;
  logic [DATA_W-1:0] edge_det;
  logic [DATA_W-1:0] clr;
  logic [DATA_W-1:0] ec_reg, ec_next;
  logic [DATA_W-1:0] mask_reg, mask_next;
  logic [DATA_W-1:0] latency_val;
  logic [DATA_W-1:0] rd_next;
  logic              irq_next;

  pio_sync_edge #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_MODE   (EDGE_MODE)
  ) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .sync_q   (sync_q),
    .edge_det (edge_det)
  );

  assign wr = chipselect & ~write_n;

  // A fresh edge on a bit being cleared wins, so the set term is ORed last.
  always_comb begin
    clr       = '0;
    mask_next = mask_reg;
    if (wr && addr_is(address, ADDR_EDGECAP)) begin
      clr = writedata;
    end
    if (wr && addr_is(address, ADDR_IRQMASK)) begin
      mask_next = writedata;
    end
    ec_next  = (ec_reg & ~clr) | edge_det;
    irq_next = |(ec_next & mask_next);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ec_reg   <= '0;
      mask_reg <= '0;
      irq      <= 1'b0;
    end else begin
      ec_reg   <= ec_next;
      mask_reg <= mask_next;
      irq      <= irq_next;
    end
  end

`ifdef PIO_IN_CAPTURE_LATENCY_EN
  logic [DATA_W-1:0] lat_reg;

  // Restarts at 0 on the irq rising edge, then counts irq-high cycles, saturating.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lat_reg <= '0;
    end else if (irq_next && !irq) begin
      lat_reg <= '0;
    end else if (irq && (lat_reg != '1)) begin
      lat_reg <= lat_reg + DATA_W'(1);
    end
  end

  assign latency_val = lat_reg;
`else
  assign latency_val = '0;
`endif

  always_comb begin
    rd_next = '0;
    case (address)
      2'(ADDR_DATA):    rd_next = sync_q;
      2'(ADDR_LATENCY): rd_next = latency_val;
      2'(ADDR_IRQMASK): rd_next = mask_reg;
      2'(ADDR_EDGECAP): rd_next = ec_reg;
      default:          rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

endmodule
